// File: rtl/alu_seq_ctrl.sv
// Control-step sequencer for register-register ALU instructions (fetch T0-T2, execute T3-T6).
// Optional macro UNARY_EN: legalises unary neg/not opcodes that skip T3 and read rb in T4.
module alu_seq_ctrl #(
    parameter int unsigned NREGS  = 16,
    parameter int unsigned OPC_W  = 5,
    parameter logic [4:0]  OP_MUL = 5'b01111,
    parameter logic [4:0]  OP_DIV = 5'b10000,
    parameter logic [4:0]  OP_MAX = 5'b10000
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             mem_rdy,
    input  logic [31:0]      ir,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic             PCout,
    output logic             MARin,
    output logic             IncPC,
    output logic             PCin,
    output logic             Read,
    output logic             MDRin,
    output logic             MDRout,
    output logic             IRin,
    output logic             Yin,
    output logic             Zlowin,
    output logic             Zhighin,
    output logic             Zlowout,
    output logic             Zhighout,
    output logic             LOin,
    output logic             HIin,
    output logic [NREGS-1:0] Rin,
    output logic [NREGS-1:0] Rout,
    output logic [OPC_W-1:0] ALUopcode
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_T0   = 3'd1;
    localparam logic [2:0] S_T1   = 3'd2;
    localparam logic [2:0] S_T2   = 3'd3;
    localparam logic [2:0] S_T3   = 3'd4;
    localparam logic [2:0] S_T4   = 3'd5;
    localparam logic [2:0] S_T5   = 3'd6;
    localparam logic [2:0] S_T6   = 3'd7;

    logic [2:0]       state_q, state_d;
    logic [4:0]       op_q;
    logic [3:0]       ra_q, rb_q, rc_q;
    logic             unary_q;
    logic             illegal_q, done_q;
    logic [OPC_W-1:0] alu_op_q;

    logic [4:0] ir_op;
    logic [3:0] ir_ra, ir_rb, ir_rc;
    logic       ir_unary, op_bad, reg_bad, dec_illegal, mul_div;
    logic       unused_ir;

    assign ir_op     = ir[31:27];
    assign ir_ra     = ir[26:23];
    assign ir_rb     = ir[22:19];
    assign ir_rc     = ir[18:15];
    assign unused_ir = ^ir[14:0];

`ifdef UNARY_EN
    assign ir_unary = (ir_op == 5'b10001) || (ir_op == 5'b10010);
`else
    assign ir_unary = 1'b0;
`endif

    // Unary ops have no rc operand, so rc is exempt from the range check.
    assign op_bad      = (ir_op > OP_MAX) && !ir_unary;
    assign reg_bad     = (32'(ir_ra) >= NREGS) || (32'(ir_rb) >= NREGS) ||
                         (!ir_unary && (32'(ir_rc) >= NREGS));
    assign dec_illegal = op_bad || reg_bad;
    assign mul_div     = (op_q == OP_MUL) || (op_q == OP_DIV);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   if (mem_rdy) state_d = S_T2;
            S_T2: begin
                if (dec_illegal)   state_d = S_IDLE;
                else if (ir_unary) state_d = S_T4;
                else               state_d = S_T3;
            end
            S_T3:   state_d = S_T4;
            S_T4:   state_d = S_T5;
            S_T5:   state_d = mul_div ? S_T6 : S_IDLE;
            S_T6:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            ra_q      <= '0;
            rb_q      <= '0;
            rc_q      <= '0;
            unary_q   <= 1'b0;
            illegal_q <= 1'b0;
            done_q    <= 1'b0;
            alu_op_q  <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q != S_IDLE) && (state_d == S_IDLE);
            if ((state_q == S_IDLE) && start)
                illegal_q <= 1'b0;
            if (state_q == S_T2) begin
                op_q    <= ir_op;
                ra_q    <= ir_ra;
                rb_q    <= ir_rb;
                rc_q    <= ir_rc;
                unary_q <= ir_unary;
                if (dec_illegal)
                    illegal_q <= 1'b1;
            end
            // Unary ops enter T4 straight from T2, before op_q holds the new opcode.
            if (state_d == S_T4)
                alu_op_q <= OPC_W'((state_q == S_T2) ? ir_op : op_q);
        end
    end

    always_comb begin
        PCout    = 1'b0;
        MARin    = 1'b0;
        IncPC    = 1'b0;
        PCin     = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zlowin   = 1'b0;
        Zhighin  = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        LOin     = 1'b0;
        HIin     = 1'b0;
        Rin      = '0;
        Rout     = '0;
        case (state_q)
            S_T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zlowin  = 1'b1;
                Zhighin = 1'b1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = mem_rdy;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                Rout = NREGS'(1) << rb_q;
                Yin  = 1'b1;
            end
            S_T4: begin
                Rout    = NREGS'(1) << (unary_q ? rb_q : rc_q);
                Zlowin  = 1'b1;
                Zhighin = 1'b1;
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (mul_div) LOin = 1'b1;
                else         Rin  = NREGS'(1) << ra_q;
            end
            S_T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign illegal   = illegal_q;
    assign ALUopcode = alu_op_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: a 16-register and an 8-register instance share stimulus.
// Control-bit vector order: PCout MARin IncPC PCin Read MDRin MDRout IRin Yin Zlowin Zhighin Zlowout Zhighout LOin HIin.
module tb_alu_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clr, start, mem_rdy;
    logic [31:0] ir;

    logic        busy, done, illegal;
    logic        PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin;
    logic        Yin, Zlowin, Zhighin, Zlowout, Zhighout, LOin, HIin;
    logic [15:0] Rin, Rout;
    logic [4:0]  ALUopcode;

    logic        busy_8, done_8, illegal_8;
    logic        PCout_8, MARin_8, IncPC_8, PCin_8, Read_8, MDRin_8, MDRout_8, IRin_8;
    logic        Yin_8, Zlowin_8, Zhighin_8, Zlowout_8, Zhighout_8, LOin_8, HIin_8;
    logic [7:0]  Rin_8, Rout_8;
    logic [4:0]  ALUopcode_8;

    logic [14:0] ctl, ctl_8;
    assign ctl   = {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin,
                    Yin, Zlowin, Zhighin, Zlowout, Zhighout, LOin, HIin};
    assign ctl_8 = {PCout_8, MARin_8, IncPC_8, PCin_8, Read_8, MDRin_8, MDRout_8, IRin_8,
                    Yin_8, Zlowin_8, Zhighin_8, Zlowout_8, Zhighout_8, LOin_8, HIin_8};

    alu_seq_ctrl #(.NREGS(16)) u_dut (
        .clk(clk), .clr(clr), .start(start), .mem_rdy(mem_rdy), .ir(ir),
        .busy(busy), .done(done), .illegal(illegal),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin), .Read(Read),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zlowin(Zlowin),
        .Zhighin(Zhighin), .Zlowout(Zlowout), .Zhighout(Zhighout), .LOin(LOin), .HIin(HIin),
        .Rin(Rin), .Rout(Rout), .ALUopcode(ALUopcode)
    );

    alu_seq_ctrl #(.NREGS(8)) u_dut8 (
        .clk(clk), .clr(clr), .start(start), .mem_rdy(mem_rdy), .ir(ir),
        .busy(busy_8), .done(done_8), .illegal(illegal_8),
        .PCout(PCout_8), .MARin(MARin_8), .IncPC(IncPC_8), .PCin(PCin_8), .Read(Read_8),
        .MDRin(MDRin_8), .MDRout(MDRout_8), .IRin(IRin_8), .Yin(Yin_8), .Zlowin(Zlowin_8),
        .Zhighin(Zhighin_8), .Zlowout(Zlowout_8), .Zhighout(Zhighout_8), .LOin(LOin_8), .HIin(HIin_8),
        .Rin(Rin_8), .Rout(Rout_8), .ALUopcode(ALUopcode_8)
    );

    localparam logic [31:0] SUB = 32'h20228000;
    localparam logic [31:0] MUL = {5'b01111, 4'd2, 4'd3, 4'd4, 15'd0};
    localparam logic [31:0] ILL = 32'hF8000000;
    localparam logic [31:0] RC9 = {5'b00100, 4'd1, 4'd2, 4'd9, 15'd0};
    localparam logic [31:0] UNA = {5'b10001, 4'd1, 4'd6, 4'd0, 15'd0};

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int t_start = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic step(input string tag, input logic [14:0] c,
                        input logic [15:0] rin_e, input logic [15:0] rout_e);
        tick;
        check({tag, ".ctl"}, 32'(ctl), 32'(c));
        check({tag, ".rin"}, 32'(Rin), 32'(rin_e));
        check({tag, ".rout"}, 32'(Rout), 32'(rout_e));
    endtask

    task automatic issue(input logic [31:0] instr);
        ir    = instr;
        start = 1'b1;
        tick;
        t_start = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input bit sel8, input int exp_lat, input string tag);
        int lat;
        lat = -1;
        for (int i = 0; i < 30; i++) begin
            if ((sel8 ? done_8 : done) === 1'b1) begin
                lat = cyc - t_start;
                break;
            end
            tick;
        end
        check(tag, 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        clr = 1'b1; start = 1'b0; mem_rdy = 1'b1; ir = '0;
        tick;
        tick;
        clr = 1'b0;
        check("rst.ctl", 32'(ctl), 32'h0);
        check("rst.busy", 32'(busy), 32'h0);
        check("rst.done", 32'(done), 32'h0);
        check("rst.illegal", 32'(illegal), 32'h0);
        check("rst.rin_rout", {Rin, Rout}, 32'h0);
        check("rst.alu", 32'(ALUopcode), 32'h0);

        // sub R0,R4,R5 with memory always ready
        issue(SUB);
        check("s.T0.ctl", 32'(ctl), 32'h7030);
        check("s.T0.busy", 32'(busy), 32'h1);
        step("s.T1", 15'h0E08, 16'h0, 16'h0);
        step("s.T2", 15'h0180, 16'h0, 16'h0);
        step("s.T3", 15'h0040, 16'h0, 16'h0010);
        check("s.T3.alu_hold", 32'(ALUopcode), 32'h0);
        step("s.T4", 15'h0030, 16'h0, 16'h0020);
        check("s.T4.alu", 32'(ALUopcode), 32'h04);
        step("s.T5", 15'h0008, 16'h0001, 16'h0);
        check("s.T5.done", 32'(done), 32'h0);
        wait_done(1'b0, 6, "s.lat");
        check("s.end.ctl", 32'(ctl), 32'h0);
        check("s.end.busy", 32'(busy), 32'h0);
        check("s.end.alu_hold", 32'(ALUopcode), 32'h04);

        // start in the done cycle is accepted; memory stalls three cycles in T1
        issue(SUB);
        check("st.T0.ctl", 32'(ctl), 32'h7030);
        mem_rdy = 1'b0;
        step("st.T1a", 15'h0608, 16'h0, 16'h0);
        step("st.T1b", 15'h0608, 16'h0, 16'h0);
        step("st.T1c", 15'h0608, 16'h0, 16'h0);
        tick;
        mem_rdy = 1'b1;
        #1;
        check("st.T1d.ctl", 32'(ctl), 32'h0E08);
        wait_done(1'b0, 9, "st.lat");

        // multiply with 64-bit write-back; a start pulse while busy is ignored
        issue(MUL);
        step("m.T1", 15'h0E08, 16'h0, 16'h0);
        step("m.T2", 15'h0180, 16'h0, 16'h0);
        step("m.T3", 15'h0040, 16'h0, 16'h0008);
        start = 1'b1;
        step("m.T4", 15'h0030, 16'h0, 16'h0010);
        start = 1'b0;
        check("m.T4.alu", 32'(ALUopcode), 32'h0F);
        step("m.T5", 15'h000A, 16'h0, 16'h0);
        step("m.T6", 15'h0005, 16'h0, 16'h0);
        wait_done(1'b0, 7, "m.lat");

        // illegal opcode ends after fetch with a sticky flag
        issue(ILL);
        check("i.T0.ctl", 32'(ctl), 32'h7030);
        step("i.T1", 15'h0E08, 16'h0, 16'h0);
        step("i.T2", 15'h0180, 16'h0, 16'h0);
        wait_done(1'b0, 3, "i.lat");
        check("i.illegal", 32'(illegal), 32'h1);
        check("i.end.ctl", 32'(ctl), 32'h0);
        tick;
        check("i.sticky", 32'(illegal), 32'h1);
        check("i.done_pulse", 32'(done), 32'h0);
        issue(SUB);
        check("i.clear_on_start", 32'(illegal), 32'h0);
        wait_done(1'b0, 6, "i.next.lat");

        // clr beats start
        clr = 1'b1; start = 1'b1;
        tick;
        clr = 1'b0; start = 1'b0;
        check("cs.busy", 32'(busy), 32'h0);
        check("cs.ctl", 32'(ctl), 32'h0);

        // rc=9: legal with 16 registers, illegal with 8; then clr during T4
        issue(RC9);
        step("r.T1", 15'h0E08, 16'h0, 16'h0);
        step("r.T2", 15'h0180, 16'h0, 16'h0);
        step("r.T3", 15'h0040, 16'h0, 16'h0004);
        check("r8.done", 32'(done_8), 32'h1);
        check("r8.illegal", 32'(illegal_8), 32'h1);
        check("r8.ctl", 32'(ctl_8), 32'h0);
        check("r16.illegal", 32'(illegal), 32'h0);
        step("r.T4", 15'h0030, 16'h0, 16'h0200);
        check("r.T4.alu", 32'(ALUopcode), 32'h04);
        clr = 1'b1;
        tick;
        clr = 1'b0;
        check("c.ctl", 32'(ctl), 32'h0);
        check("c.busy", 32'(busy), 32'h0);
        check("c.rin_rout", {Rin, Rout}, 32'h0);
        check("c.alu", 32'(ALUopcode), 32'h0);
        check("c.done", 32'(done), 32'h0);
        check("c.illegal8", 32'(illegal_8), 32'h0);
        check("c.alu8", 32'(ALUopcode_8), 32'h0);

        // unary neg R1,R6
        issue(UNA);
        step("u.T1", 15'h0E08, 16'h0, 16'h0);
        step("u.T2", 15'h0180, 16'h0, 16'h0);
`ifdef UNARY_EN
        step("u.T4", 15'h0030, 16'h0, 16'h0040);
        check("u.T4.alu", 32'(ALUopcode), 32'h11);
        step("u.T5", 15'h0008, 16'h0002, 16'h0);
        wait_done(1'b0, 5, "u.lat");
        check("u.illegal", 32'(illegal), 32'h0);
`else
        wait_done(1'b0, 3, "u.lat");
        check("u.illegal", 32'(illegal), 32'h1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Parametrised control-step sequencer for register-register ALU instructions. It replaces hand-timed control stimulus with a synchronous FSM that drives every datapath select and enable through fetch (T0–T2) and execute (T3–T6). It sits beside `datapath`: its outputs connect to the datapath control inputs, and the datapath's IR contents feed back on `ir`. It adds a memory-ready stall, HI/LO write-back for multiply/divide, and an illegal-instruction flag.

## Interface
- NREGS, 16: number of general registers, 2..16; `Rin`/`Rout` width.
- OPC_W, 5: ALU opcode width; instruction opcode field is IR[31:27].
- OP_MUL, 5'b01111: opcode needing 64-bit write-back.
- OP_DIV, 5'b10000: opcode needing 64-bit write-back.
- OP_MAX, 5'b10000: highest legal two-operand opcode.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- clr  in  1  reset, synchronous, active-high.
- start  in  1  begin one instruction; sampled only in IDLE.
- mem_rdy  in  1  memory data valid during T1.
- ir  in  32  IR value from datapath; fields: opcode [31:27], ra [26:23], rb [22:19], rc [18:15].
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in the cycle after the final step.
- illegal  out  1  sticky error; cleared by `clr` or the next accepted `start`.
- PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin, Zlowin, Zhighin, Zlowout, Zhighout, LOin, HIin  out  1 each  datapath controls.
- Rin  out  NREGS  one-hot register write enable.
- Rout  out  NREGS  one-hot register bus-drive select.
- ALUopcode  out  OPC_W  ALU function.

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, T6.
- All controls are Moore outputs decoded from state and the latched fields. Each is high for the whole state.
- IDLE: all controls 0. When `start`=1, go to T0 and clear `illegal`.
- T0: PCout, MARin, IncPC, Zlowin, Zhighin. Go to T1.
- T1: Zlowout, PCin, Read, MDRin. Stay in T1 while `mem_rdy`=0.
  - PCin and IncPC-driven writes fire only in the exit cycle, so PCin = `mem_rdy`.
  - Read and MDRin stay high throughout the stall.
- T2: MDRout, IRin. On exit, latch opcode, ra, rb and rc from `ir` into internal registers. Later steps use only the latched copies.
- Decode at T2 exit:
  - opcode > OP_MAX, or any register field ≥ NREGS: set `illegal`, go to IDLE, and pulse `done`. No execute controls are asserted.
- T3: Rout[rb], Yin.
- T4: Rout[rc], ALUopcode = opcode, Zlowin, Zhighin.
- T5:
  - Normal opcode: Zlowout, Rin[ra]. Then IDLE and `done`.
  - OP_MUL or OP_DIV: Zlowout, LOin. Then T6.
- T6: Zhighout, HIin. Then IDLE and `done`.
- ALUopcode holds its last value outside T4. Reset value is 0.
- Rin and Rout are always one-hot or all-zero. No two bus drivers are ever high together.
- `start` while busy is ignored. No queuing.

## Timing
- Reset (`clr`=1 at an edge): state=IDLE and every output is 0, including `illegal` and ALUopcode. This holds mid-instruction as well. Any partially written register is not rolled back.
- Latency from the `start` edge to `done`, with `mem_rdy` tied high:
  - Normal op: 6 cycles (T0–T5).
  - Mul/div: 7 cycles.
  - Illegal: 3 cycles.
- Each cycle of `mem_rdy`=0 in T1 adds exactly one cycle.
- `done` is registered and asserts in the IDLE cycle following the last step. `start` in that same cycle is accepted.
- `clr` and `start` asserted together: `clr` wins.

## Configuration
- UNARY_EN defined: opcodes 5'b10001 (neg) and 5'b10010 (not) are legal.
  - Their execute path skips T3 and drives Rout[rb] in T4. `rc` is ignored and not range-checked.
  - Normal-op latency for these opcodes is 5 cycles.
- UNARY_EN undefined: these opcodes exceed OP_MAX and raise `illegal`.

## Test plan
- Reset, then `ir`=32'h20228000 (sub R0,R4,R5), `start` pulse, `mem_rdy`=1 -> T3 Rout=16'h0010; T4 Rout=16'h0020 with ALUopcode=5'b00100; T5 Rin=16'h0001; `done` 6 cycles after `start`.
- Same instruction with `mem_rdy` low for 3 cycles in T1 -> Read/MDRin high 4 cycles; PCin high only in the last; `done` at cycle 9.
- `ir` with opcode OP_MUL, ra=2, rb=3, rc=4 -> T5 Zlowout+LOin; T6 Zhighout+HIin; Rin never nonzero; `done` at cycle 7.
- `ir`=32'hF8000000 (opcode 5'b11111) -> `illegal`=1 after T2; no Yin/Zlowin in execute; `done` at cycle 3; next `start` clears `illegal`.
- NREGS=8 and rc=9 -> `illegal`=1. Separately, `clr` in T4 -> next cycle all outputs 0 and state IDLE.
- UNARY_EN build, opcode 5'b10001, ra=1, rb=6 -> no T3; T4 Rout=bit 6; T5 Rin=bit 1; `done` at cycle 5.
